// File: rtl/seq_subtractor_64_if.sv
// Operand/result bundle for seq_subtractor_64: valid/ready request side and valid/ready result side.
// The master drives the operands and out_ready. The slave is the subtractor.
interface seq_subtractor_64_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             borrow_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, a, b, borrow_in, out_ready,
        input  in_ready, out_valid, diff, borrow_out, overflow, zero
    );

    modport slave (
        input  in_valid, a, b, borrow_in, out_ready,
        output in_ready, out_valid, diff, borrow_out, overflow, zero
    );
endinterface

// File: rtl/seq_subtractor_64.sv
// Multi-cycle a - b - borrow_in, one CHUNK-bit slice per clock, LSB first; SEQ_SUB_SAT_EN adds a signed clamp.
// Latency: out_valid rises WIDTH/CHUNK cycles after the accept edge.
// Backpressure: the result is held in DONE until out_ready; in_ready is high only in IDLE.
module seq_subtractor_64 #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    seq_subtractor_64_if.slave bus
);
    localparam int NSL = WIDTH / CHUNK;
    localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSL - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_diff;
    logic             r_sa;
    logic             r_sb;
    logic             r_borrow;
    logic [CW-1:0]    r_cnt;
    logic             r_borrow_out;
    logic             r_overflow;
    logic             r_zero;

    logic [CHUNK-1:0] w_slice;
    logic             w_bo;
    logic [WIDTH-1:0] w_diff_full;
    logic [WIDTH-1:0] w_diff_final;
    logic             w_ovf;
    logic             w_in_ready;
    logic             w_out_valid;

    // Operands shift right one slice per cycle, so the active slice is always the low CHUNK bits.
    assign {w_bo, w_slice} = {1'b0, r_a[CHUNK-1:0]} - {1'b0, r_b[CHUNK-1:0]}
                           - {{CHUNK{1'b0}}, r_borrow};

    // Result slices enter at the top and walk down; after NSL slices the word is in place.
    assign w_diff_full = (r_diff >> CHUNK) | (WIDTH'(w_slice) << (WIDTH - CHUNK));
    assign w_ovf       = (r_sa != r_sb) && (w_diff_full[WIDTH-1] != r_sa);

`ifdef SEQ_SUB_SAT_EN
    assign w_diff_final = !w_ovf ? w_diff_full :
                          r_sa   ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
    assign w_diff_final = w_diff_full;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) w_state_nxt = BUSY;
            end
            BUSY: begin
                if (r_cnt == LAST) w_state_nxt = DONE;
            end
            DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a          <= '0;
            r_b          <= '0;
            r_diff       <= '0;
            r_sa         <= 1'b0;
            r_sb         <= 1'b0;
            r_borrow     <= 1'b0;
            r_cnt        <= '0;
            r_borrow_out <= 1'b0;
            r_overflow   <= 1'b0;
            r_zero       <= 1'b0;
        end else begin
            if (r_state == IDLE && bus.in_valid) begin
                r_a      <= bus.a;
                r_b      <= bus.b;
                r_sa     <= bus.a[WIDTH-1];
                r_sb     <= bus.b[WIDTH-1];
                r_borrow <= bus.borrow_in;
                r_cnt    <= '0;
            end else if (r_state == BUSY) begin
                r_a      <= r_a >> CHUNK;
                r_b      <= r_b >> CHUNK;
                r_borrow <= w_bo;
                r_cnt    <= r_cnt + CW'(1);
                if (r_cnt == LAST) begin
                    r_diff       <= w_diff_final;
                    r_borrow_out <= w_bo;
                    r_overflow   <= w_ovf;
                    r_zero       <= (w_diff_final == '0);
                end else begin
                    r_diff <= w_diff_full;
                end
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = w_out_valid;
    assign bus.diff       = r_diff;
    assign bus.borrow_out = r_borrow_out;
    assign bus.overflow   = r_overflow;
    assign bus.zero       = r_zero;
endmodule
